regfile_sequencer: RTL and testbench

Multi-cycle micro-sequencer that drives the register file's control inputs (`ctl_dest`, `ctl_sbus`, `ctl_address`) and the ALU operand latches. It takes one register-transfer command at a time over a valid/ready handshake and expands it into a fixed read-A / read-B / write-back cycle sequence. It sits between the instruction decode stage and the regfile/ALU datapath, and is the only block that drives regfile control.

---
 rtl/regfile_sequencer_pkg.sv | 47 ++++
 rtl/regfile_sequencer.sv | 141 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_pkg.sv
// Shared regfile/ALU control encodings and the sequencer state type.
// Port codes for destination and read-select are fixed by the regfile.
package globals;

  localparam int WORDLEN = 16;

  localparam logic [3:0] DST_R0   = 4'h0;
  localparam logic [3:0] DST_R1   = 4'h1;
  localparam logic [3:0] DST_R2   = 4'h2;
  localparam logic [3:0] DST_R3   = 4'h3;
  localparam logic [3:0] DST_R4   = 4'h4;
  localparam logic [3:0] DST_R5   = 4'h5;
  localparam logic [3:0] DST_R6   = 4'h6;
  localparam logic [3:0] DST_R7   = 4'h7;
  localparam logic [3:0] DST_NONE = 4'hF;

  localparam logic [3:0] SBUS_R0       = 4'h0;
  localparam logic [3:0] SBUS_R1       = 4'h1;
  localparam logic [3:0] SBUS_R2       = 4'h2;
  localparam logic [3:0] SBUS_R3       = 4'h3;
  localparam logic [3:0] SBUS_R4       = 4'h4;
  localparam logic [3:0] SBUS_R5       = 4'h5;
  localparam logic [3:0] SBUS_R6       = 4'h6;
  localparam logic [3:0] SBUS_R7       = 4'h7;
  localparam logic [3:0] SBUS_ADDCONST = 4'h8;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_MOV = 2'd1;
  localparam logic [1:0] OP_LDC = 2'd2;
  localparam logic [1:0] OP_ALU = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    WRITE  = 2'd3
  } seq_state_t;

  function automatic logic [3:0] dst_of(input logic [2:0] r);
    return DST_R0 + {1'b0, r};
  endfunction

  function automatic logic [3:0] sbus_of(input logic [2:0] r);
    return SBUS_R0 + {1'b0, r};
  endfunction

endpackage

// File: rtl/regfile_sequencer.sv
// Expands one register-transfer command into read-A / read-B / write-back
// cycles on the regfile control bus; every control output is registered.
module regfile_sequencer #(
  parameter int WORDLEN = globals::WORDLEN,
  parameter int IMMW    = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [2:0]      cmd_rd,
  input  logic [2:0]      cmd_rs1,
  input  logic [2:0]      cmd_rs2,
  input  logic [2:0]      cmd_fn,
  input  logic [IMMW-1:0] cmd_imm,
  output logic [3:0]      ctl_dest,
  output logic [3:0]      ctl_sbus,
  output logic [IMMW-1:0] ctl_address,
  output logic            ctl_latch_a,
  output logic            ctl_latch_b,
  output logic [2:0]      ctl_alu_fn,
  output logic            ctl_wb_sel,
  output logic            done
);
  import globals::*;

  // The constant is driven onto the datapath, so it cannot be wider than a word.
  if (IMMW > WORDLEN) begin : g_immw_check
    $error("IMMW must not exceed WORDLEN");
  end

  seq_state_t      state_q;
  logic            ready_q;
  logic [3:0]      dest_q;
  logic [3:0]      sbus_q;
  logic [IMMW-1:0] addr_q;
  logic            la_q;
  logic            lb_q;
  logic [2:0]      alu_fn_q;
  logic            wb_q;
  logic            done_q;

  // Fields still needed after READ_A; rs1/imm are consumed at acceptance.
  logic [1:0]      op_q;
  logic [2:0]      rd_q;
  logic [2:0]      rs2_q;
  logic [2:0]      fn_q;

  logic            accept;
  assign accept = cmd_valid && ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      dest_q   <= DST_NONE;
      sbus_q   <= SBUS_R0;
      addr_q   <= '0;
      la_q     <= 1'b0;
      lb_q     <= 1'b0;
      alu_fn_q <= '0;
      wb_q     <= 1'b0;
      done_q   <= 1'b0;
      op_q     <= OP_NOP;
      rd_q     <= '0;
      rs2_q    <= '0;
      fn_q     <= '0;
    end else begin
      dest_q   <= DST_NONE;
      sbus_q   <= SBUS_R0;
      addr_q   <= '0;
      la_q     <= 1'b0;
      lb_q     <= 1'b0;
      alu_fn_q <= '0;
      wb_q     <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE, WRITE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          if (accept) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rs2_q <= cmd_rs2;
            fn_q  <= cmd_fn;
            if (cmd_op == OP_NOP) begin
              done_q <= 1'b1;
            end else begin
              state_q <= READ_A;
              ready_q <= 1'b0;
              la_q    <= 1'b1;
              if (cmd_op == OP_LDC) begin
                sbus_q <= SBUS_ADDCONST;
                addr_q <= cmd_imm;
              end else begin
                sbus_q <= sbus_of(cmd_rs1);
              end
            end
          end
        end
        READ_A: begin
          if (op_q == OP_ALU) begin
            state_q <= READ_B;
            ready_q <= 1'b0;
            sbus_q  <= sbus_of(rs2_q);
            lb_q    <= 1'b1;
          end else begin
            state_q <= WRITE;
            ready_q <= 1'b1;
            dest_q  <= dst_of(rd_q);
            done_q  <= 1'b1;
          end
        end
        READ_B: begin
          state_q  <= WRITE;
          ready_q  <= 1'b1;
          dest_q   <= dst_of(rd_q);
          wb_q     <= 1'b1;
          alu_fn_q <= fn_q;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready   = ready_q;
  assign ctl_dest    = dest_q;
  assign ctl_sbus    = sbus_q;
  assign ctl_address = addr_q;
  assign ctl_latch_a = la_q;
  assign ctl_latch_b = lb_q;
  assign ctl_alu_fn  = alu_fn_q;
  assign ctl_wb_sel  = wb_q;
  assign done        = done_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: a per-cycle command-schedule model
// plus a small regfile/ALU model driven by the control outputs.
module tb_regfile_sequencer;
  import globals::*;

  localparam int IMMW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'd0;
  logic [2:0]      cmd_rd = 3'd0;
  logic [2:0]      cmd_rs1 = 3'd0;
  logic [2:0]      cmd_rs2 = 3'd0;
  logic [2:0]      cmd_fn = 3'd0;
  logic [IMMW-1:0] cmd_imm = '0;
  logic [3:0]      ctl_dest;
  logic [3:0]      ctl_sbus;
  logic [IMMW-1:0] ctl_address;
  logic            ctl_latch_a;
  logic            ctl_latch_b;
  logic [2:0]      ctl_alu_fn;
  logic            ctl_wb_sel;
  logic            done;

  regfile_sequencer #(.WORDLEN(16), .IMMW(IMMW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_fn(cmd_fn), .cmd_imm(cmd_imm),
    .ctl_dest(ctl_dest), .ctl_sbus(ctl_sbus), .ctl_address(ctl_address),
    .ctl_latch_a(ctl_latch_a), .ctl_latch_b(ctl_latch_b),
    .ctl_alu_fn(ctl_alu_fn), .ctl_wb_sel(ctl_wb_sel), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected observable behaviour of one cycle.
  typedef struct packed {
    logic            chk_rd;
    logic            chk_addr;
    logic            wr;
    logic [3:0]      dest;
    logic [3:0]      sbus;
    logic [IMMW-1:0] addr;
    logic            la;
    logic            lb;
    logic [2:0]      fn;
    logic            wb;
    logic            dn;
  } exp_t;

  exp_t pend[$];
  exp_t cur;

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.dest = 4'hF;
    return e;
  endfunction

  task automatic push_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [2:0] fn, input logic [IMMW-1:0] imm);
    exp_t e;
    if (op == 2'd0) begin
      e = idle_e();
      e.dn = 1'b1;
      pend.push_back(e);
    end else begin
      e = idle_e();
      e.chk_rd = 1'b1;
      e.chk_addr = 1'b1;
      e.la = 1'b1;
      e.sbus = (op == 2'd2) ? 4'h8 : {1'b0, rs1};
      e.addr = (op == 2'd2) ? imm : '0;
      pend.push_back(e);
      if (op == 2'd3) begin
        e = idle_e();
        e.chk_rd = 1'b1;
        e.lb = 1'b1;
        e.sbus = {1'b0, rs2};
        pend.push_back(e);
      end
      e = idle_e();
      e.wr = 1'b1;
      e.dn = 1'b1;
      e.dest = {1'b0, rd};
      e.wb = (op == 2'd3);
      e.fn = (op == 2'd3) ? fn : 3'd0;
      pend.push_back(e);
    end
  endtask

  // Schedule model: ready only when nothing of the current command remains.
  initial cur = idle_e();
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      cur = idle_e();
    end
    chk("m_ready", {31'd0, cmd_ready}, {31'd0, pend.size() == 0});
    chk("m_dest", {28'd0, ctl_dest}, {28'd0, cur.dest});
    chk("m_latch_a", {31'd0, ctl_latch_a}, {31'd0, cur.la});
    chk("m_latch_b", {31'd0, ctl_latch_b}, {31'd0, cur.lb});
    chk("m_done", {31'd0, done}, {31'd0, cur.dn});
    if (cur.chk_rd) chk("m_sbus", {28'd0, ctl_sbus}, {28'd0, cur.sbus});
    if (cur.chk_addr) chk("m_addr", {20'd0, ctl_address}, {20'd0, cur.addr});
    if (cur.wr) begin
      chk("m_wb_sel", {31'd0, ctl_wb_sel}, {31'd0, cur.wb});
      chk("m_alu_fn", {29'd0, ctl_alu_fn}, {29'd0, cur.fn});
    end
    if (rst_n && cmd_valid && pend.size() == 0)
      push_cmd(cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_fn, cmd_imm);
    cur = (pend.size() != 0) ? pend.pop_front() : idle_e();
  end

  // Regfile + operand latches + ALU, driven by the sequencer outputs.
  logic [15:0] rf [8] = '{16'h0000, 16'h0101, 16'h0202, 16'h0303,
                          16'h0404, 16'h0505, 16'h0606, 16'h0707};
  logic [15:0] opa = 16'h0;
  logic [15:0] opb = 16'h0;

  function automatic logic [15:0] alu(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [15:0] sv;
    sv = (ctl_sbus < 4'd8) ? rf[ctl_sbus[2:0]] : {4'h0, ctl_address};
    if (ctl_latch_a) opa <= sv;
    if (ctl_latch_b) opb <= sv;
    if (ctl_dest != 4'hF) rf[ctl_dest[2:0]] <= ctl_wb_sel ? alu(ctl_alu_fn, opa, opb) : opa;
  end

  task automatic send(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [2:0] fn, input logic [IMMW-1:0] imm,
                      output int acc);
    int n;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_fn = fn; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    acc = cyc;
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a1, a2;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_dest", {28'd0, ctl_dest}, 32'hF);
    chk("rst_sbus", {28'd0, ctl_sbus}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_dest", {28'd0, ctl_dest}, 32'hF);
    chk("post_rst_sbus", {28'd0, ctl_sbus}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    // LDC r3 <- 0x0A5
    send(2'd2, 3'd3, 3'd0, 3'd0, 3'd0, 12'h0A5, a1);
    chk("ldc_t1_sbus", {28'd0, ctl_sbus}, 32'd8);
    chk("ldc_t1_addr", {20'd0, ctl_address}, 32'h0A5);
    chk("ldc_t1_la", {31'd0, ctl_latch_a}, 32'd1);
    step();
    chk("ldc_t2_dest", {28'd0, ctl_dest}, 32'd3);
    chk("ldc_t2_wb", {31'd0, ctl_wb_sel}, 32'd0);
    chk("ldc_t2_done", {31'd0, done}, 32'd1);
    step();
    chk("ldc_t3_dest", {28'd0, ctl_dest}, 32'hF);
    chk("ldc_r3", {16'd0, rf[3]}, 32'h00A5);

    // ALU r5 <- r1 | r2
    send(2'd3, 3'd5, 3'd1, 3'd2, 3'd3, 12'h000, a1);
    chk("alu_t1_sbus", {28'd0, ctl_sbus}, 32'd1);
    chk("alu_t1_la", {31'd0, ctl_latch_a}, 32'd1);
    chk("alu_t1_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("alu_t2_sbus", {28'd0, ctl_sbus}, 32'd2);
    chk("alu_t2_lb", {31'd0, ctl_latch_b}, 32'd1);
    chk("alu_t2_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("alu_t3_dest", {28'd0, ctl_dest}, 32'd5);
    chk("alu_t3_wb", {31'd0, ctl_wb_sel}, 32'd1);
    chk("alu_t3_fn", {29'd0, ctl_alu_fn}, 32'd3);
    chk("alu_t3_done", {31'd0, done}, 32'd1);
    step();
    chk("alu_r5", {16'd0, rf[5]}, 32'h0303);

    // Back-to-back MOV r2 <- r1, MOV r4 <- r2
    send(2'd1, 3'd2, 3'd1, 3'd0, 3'd0, 12'h000, a1);
    send(2'd1, 3'd4, 3'd2, 3'd0, 3'd0, 12'h000, a2);
    chk("b2b_gap", a2 - a1, 32'd2);
    chk("b2b_sbus", {28'd0, ctl_sbus}, 32'd2);
    step();
    chk("b2b_dest", {28'd0, ctl_dest}, 32'd4);
    step();
    chk("b2b_r2", {16'd0, rf[2]}, 32'h0101);
    chk("b2b_r4", {16'd0, rf[4]}, 32'h0101);

    // Reset during READ_B of ALU r5 <- r3 + r4
    send(2'd3, 3'd5, 3'd3, 3'd4, 3'd0, 12'h000, a1);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dest", {28'd0, ctl_dest}, 32'hF);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_lb", {31'd0, ctl_latch_b}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("mid_rst_r5", {16'd0, rf[5]}, 32'h0303);

    // NOP
    send(2'd0, 3'd6, 3'd1, 3'd2, 3'd0, 12'h000, a1);
    chk("nop_done", {31'd0, done}, 32'd1);
    chk("nop_dest", {28'd0, ctl_dest}, 32'hF);
    step();
    chk("nop_done_end", {31'd0, done}, 32'd0);
    chk("nop_r6", {16'd0, rf[6]}, 32'h0606);

    // ALU r6 <- r3 - r1 with junk fields while busy
    send(2'd3, 3'd6, 3'd3, 3'd1, 3'd1, 12'h000, a1);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_rd = 3'd7; cmd_rs1 = 3'd0; cmd_rs2 = 3'd7;
    cmd_fn = 3'd5; cmd_imm = 12'hFFF;
    chk("ign_t1_sbus", {28'd0, ctl_sbus}, 32'd3);
    chk("ign_t1_addr", {20'd0, ctl_address}, 32'd0);
    step();
    cmd_op = 2'd1; cmd_rd = 3'd0; cmd_rs1 = 3'd6; cmd_rs2 = 3'd4; cmd_fn = 3'd2;
    chk("ign_t2_sbus", {28'd0, ctl_sbus}, 32'd1);
    chk("ign_t2_lb", {31'd0, ctl_latch_b}, 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("ign_t3_dest", {28'd0, ctl_dest}, 32'd6);
    chk("ign_t3_fn", {29'd0, ctl_alu_fn}, 32'd1);
    chk("ign_t3_wb", {31'd0, ctl_wb_sel}, 32'd1);
    step();
    chk("ign_t4_dest", {28'd0, ctl_dest}, 32'hF);
    step();
    chk("ign_r6", {16'd0, rf[6]}, 32'hFFA4);
    chk("ign_r7", {16'd0, rf[7]}, 32'h0707);
    chk("ign_r0", {16'd0, rf[0]}, 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
